// File: rtl/decode_stage.sv
// MIPS decode stage: one registered slot between fetch and execute with valid/ready on both sides.
// Inserts a single bubble on a load-use hazard; flush empties the slot and blocks the input.
module decode_stage #(
   parameter int DATA_W    = 32,
   parameter bit BRANCH_EN = 1'b1,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst,
   input  logic [31:0]       pc_plus4,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              GP_WE,
   output logic              ALU_SRC,
   output logic              U,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [3:0]        ALU_OP,
   output logic [3:0]        GP_MUX_SEL,
   output logic [3:0]        PC_MUX_SEL,
   output logic [1:0]        SHIFT_OP,
   output logic [3:0]        BCE_OP,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd_dest,
   output logic [4:0]        shamt,
   output logic [DATA_W-1:0] imm,
   output logic [31:0]       pc_plus4_q,
   output logic              illegal
);

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR  = 6'h25, F_SLT = 6'h2A;

   typedef struct packed {
      logic              valid;
      logic              gp_we;
      logic              alu_src;
      logic              u;
      logic              mem_read;
      logic              mem_write;
      logic [3:0]        alu_op;
      logic [3:0]        gp_mux;
      logic [3:0]        pc_mux;
      logic [1:0]        shift_op;
      logic [3:0]        bce_op;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        rd_dest;
      logic [4:0]        shamt;
      logic [DATA_W-1:0] imm;
      logic [31:0]       pc_plus4;
      logic              illegal;
   } stage_t;

   stage_t     d, q;
   logic [5:0] op, funct;
   logic       zext, uses_rs, uses_rt, hit, stall, advance, load;

   assign op    = inst[31:26];
   assign funct = inst[5:0];

   always_comb begin
      d          = '0;
      zext       = 1'b0;
      d.valid    = 1'b1;
      d.rs       = inst[25:21];
      d.rt       = inst[20:16];
      d.shamt    = inst[10:6];
      d.pc_plus4 = pc_plus4;
      case (op)
         OP_RTYPE: begin
            d.gp_we   = 1'b1;
            d.rd_dest = inst[15:11];
            case (funct)
               F_ADD: d.alu_op = 4'd0;
               F_SUB: d.alu_op = 4'd2;
               F_AND: d.alu_op = 4'd4;
               F_OR:  d.alu_op = 4'd5;
               F_SLT: d.alu_op = 4'd10;
               F_SLL: begin d.shift_op = 2'b00; d.gp_mux = 4'd2; end
               F_SRL: begin d.shift_op = 2'b10; d.gp_mux = 4'd2; end
               F_JR:  begin d.gp_we = 1'b0; d.pc_mux = 4'd3; d.rd_dest = 5'd0; end
               default: begin d.illegal = 1'b1; d.gp_we = 1'b0; d.rd_dest = 5'd0; end
            endcase
         end
         OP_LW: begin
            d.gp_we = 1'b1; d.mem_read = 1'b1; d.alu_src = 1'b1;
            d.gp_mux = 4'd1; d.rd_dest = inst[20:16];
         end
         OP_SW: begin d.mem_write = 1'b1; d.alu_src = 1'b1; end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            d.gp_we = 1'b1; d.alu_src = 1'b1; d.rd_dest = inst[20:16];
            case (op)
               OP_SLTI: d.alu_op = 4'd10;
               OP_ANDI: begin d.alu_op = 4'd4; d.u = 1'b1; zext = 1'b1; end
               OP_ORI:  begin d.alu_op = 4'd5; d.u = 1'b1; zext = 1'b1; end
               default: d.alu_op = 4'd0;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            if (BRANCH_EN) begin
               d.alu_op = 4'd2;
               d.pc_mux = 4'd1;
               d.bce_op = (op == OP_BEQ) ? 4'd1 : 4'd2;
            end else begin
               d.illegal = 1'b1;
            end
         end
         OP_J:   d.pc_mux = 4'd2;
         OP_JAL: begin d.pc_mux = 4'd2; d.gp_we = 1'b1; d.gp_mux = 4'd3; d.rd_dest = 5'd31; end
         default: d.illegal = 1'b1;
      endcase
      // $0 is hardwired, so a write to it is dropped here rather than in writeback
      if (d.rd_dest == 5'd0) d.gp_we = 1'b0;
      d.imm = zext ? {{(DATA_W-16){1'b0}}, inst[15:0]} : {{(DATA_W-16){inst[15]}}, inst[15:0]};
   end

   always_comb begin
      uses_rs = 1'b1;
      if (op == OP_J || op == OP_JAL) uses_rs = 1'b0;
      if (op == OP_RTYPE && (funct == F_SLL || funct == F_SRL)) uses_rs = 1'b0;
      uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   end

   assign hit      = (uses_rs && (inst[25:21] == q.rd_dest)) || (uses_rt && (inst[20:16] == q.rd_dest));
   assign stall    = HAZARD_EN && q.valid && q.mem_read && (q.rd_dest != 5'd0) && in_valid && hit;
   assign advance  = !q.valid || out_ready;
   assign in_ready = !rst && advance && !stall && !flush;
   assign load     = in_valid && in_ready;

   // an empty slot carries an all-zero bundle so nothing downstream acts on stale controls
   always_ff @(posedge clk) begin
      if (rst || flush || (advance && !load)) q <= '0;
      else if (load)                          q <= d;
   end

   assign out_valid  = q.valid;
   assign GP_WE      = q.gp_we;
   assign ALU_SRC    = q.alu_src;
   assign U          = q.u;
   assign MemRead    = q.mem_read;
   assign MemWrite   = q.mem_write;
   assign ALU_OP     = q.alu_op;
   assign GP_MUX_SEL = q.gp_mux;
   assign PC_MUX_SEL = q.pc_mux;
   assign SHIFT_OP   = q.shift_op;
   assign BCE_OP     = q.bce_op;
   assign rs         = q.rs;
   assign rt         = q.rt;
   assign rd_dest    = q.rd_dest;
   assign shamt      = q.shamt;
   assign imm        = q.imm;
   assign pc_plus4_q = q.pc_plus4;
   assign illegal    = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a full-feature instance and a BRANCH_EN=0/HAZARD_EN=0 instance share
// the input stream; each is compared every cycle against its own reference model.
module tb_decode_stage;

   typedef struct packed {
      logic        valid;
      logic        gp_we;
      logic        alu_src;
      logic        u;
      logic        mem_read;
      logic        mem_write;
      logic [3:0]  alu_op;
      logic [3:0]  gp_mux;
      logic [3:0]  pc_mux;
      logic [1:0]  shift_op;
      logic [3:0]  bce_op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic        illegal;
   } ost_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush, out_ready;
   logic [31:0] inst, pc_plus4;

   logic        in_ready [2];
   logic        out_valid [2];
   logic        gp_we [2];
   logic        alu_src [2];
   logic        u [2];
   logic        mem_read [2];
   logic        mem_write [2];
   logic [3:0]  alu_op [2];
   logic [3:0]  gp_mux [2];
   logic [3:0]  pc_mux [2];
   logic [1:0]  shift_op [2];
   logic [3:0]  bce_op [2];
   logic [4:0]  rs [2];
   logic [4:0]  rt [2];
   logic [4:0]  rd_dest [2];
   logic [4:0]  shamt [2];
   logic [31:0] imm [2];
   logic [31:0] pc4_q [2];
   logic        illegal [2];
   ost_t        obs [2];

   ost_t exp_q [2];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   acc0 = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      decode_stage #(.DATA_W(32), .BRANCH_EN(g == 0), .HAZARD_EN(g == 0)) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
         .inst(inst), .pc_plus4(pc_plus4), .flush(flush),
         .out_valid(out_valid[g]), .out_ready(out_ready),
         .GP_WE(gp_we[g]), .ALU_SRC(alu_src[g]), .U(u[g]), .MemRead(mem_read[g]),
         .MemWrite(mem_write[g]), .ALU_OP(alu_op[g]), .GP_MUX_SEL(gp_mux[g]),
         .PC_MUX_SEL(pc_mux[g]), .SHIFT_OP(shift_op[g]), .BCE_OP(bce_op[g]),
         .rs(rs[g]), .rt(rt[g]), .rd_dest(rd_dest[g]), .shamt(shamt[g]),
         .imm(imm[g]), .pc_plus4_q(pc4_q[g]), .illegal(illegal[g])
      );
      assign obs[g] = {out_valid[g], gp_we[g], alu_src[g], u[g], mem_read[g], mem_write[g],
                       alu_op[g], gp_mux[g], pc_mux[g], shift_op[g], bce_op[g],
                       rs[g], rt[g], rd_dest[g], shamt[g], imm[g], pc4_q[g], illegal[g]};
   end

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Reference decode: instruction table by mnemonic
   function automatic ost_t decode_ref(input logic [31:0] i, input logic [31:0] pc4, input bit br_en);
      ost_t r;
      bit   zext;
      r = '0; zext = 1'b0;
      r.valid = 1'b1; r.rs = i[25:21]; r.rt = i[20:16]; r.shamt = i[10:6]; r.pc4 = pc4;
      case (i[31:26])
         6'h00: case (i[5:0])
                   6'h20: begin r.gp_we = 1; r.rd = i[15:11]; r.alu_op = 0;  end
                   6'h22: begin r.gp_we = 1; r.rd = i[15:11]; r.alu_op = 2;  end
                   6'h24: begin r.gp_we = 1; r.rd = i[15:11]; r.alu_op = 4;  end
                   6'h25: begin r.gp_we = 1; r.rd = i[15:11]; r.alu_op = 5;  end
                   6'h2A: begin r.gp_we = 1; r.rd = i[15:11]; r.alu_op = 10; end
                   6'h00: begin r.gp_we = 1; r.rd = i[15:11]; r.shift_op = 0; r.gp_mux = 2; end
                   6'h02: begin r.gp_we = 1; r.rd = i[15:11]; r.shift_op = 2; r.gp_mux = 2; end
                   6'h08: r.pc_mux = 3;
                   default: r.illegal = 1;
                endcase
         6'h23: begin r.gp_we = 1; r.mem_read = 1; r.alu_src = 1; r.gp_mux = 1; r.rd = i[20:16]; end
         6'h2B: begin r.mem_write = 1; r.alu_src = 1; end
         6'h08: begin r.gp_we = 1; r.alu_src = 1; r.rd = i[20:16]; r.alu_op = 0;  end
         6'h0A: begin r.gp_we = 1; r.alu_src = 1; r.rd = i[20:16]; r.alu_op = 10; end
         6'h0C: begin r.gp_we = 1; r.alu_src = 1; r.rd = i[20:16]; r.alu_op = 4; r.u = 1; zext = 1; end
         6'h0D: begin r.gp_we = 1; r.alu_src = 1; r.rd = i[20:16]; r.alu_op = 5; r.u = 1; zext = 1; end
         6'h04: if (br_en) begin r.alu_op = 2; r.pc_mux = 1; r.bce_op = 1; end else r.illegal = 1;
         6'h05: if (br_en) begin r.alu_op = 2; r.pc_mux = 1; r.bce_op = 2; end else r.illegal = 1;
         6'h02: r.pc_mux = 2;
         6'h03: begin r.pc_mux = 2; r.gp_we = 1; r.gp_mux = 3; r.rd = 31; end
         default: r.illegal = 1;
      endcase
      if (r.rd == 0) r.gp_we = 0;
      r.imm = zext ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
      return r;
   endfunction

   function automatic bit depends_on(input logic [31:0] i, input logic [4:0] dst);
      bit ur, ut;
      ur = !(i[31:26] == 6'h02 || i[31:26] == 6'h03 ||
             (i[31:26] == 6'h00 && (i[5:0] == 6'h00 || i[5:0] == 6'h02)));
      ut = (i[31:26] == 6'h00) || (i[31:26] == 6'h2B) || (i[31:26] == 6'h04) || (i[31:26] == 6'h05);
      return (ur && i[25:21] == dst) || (ut && i[20:16] == dst);
   endfunction

   // One clock: check in_ready before the edge, advance the models, check outputs after it
   task automatic cyc();
      ost_t nxt [2];
      bit   rdy, adv, stl;
      #1;
      for (int k = 0; k < 2; k++) begin
         adv = !exp_q[k].valid || out_ready;
         stl = (k == 0) && exp_q[k].valid && exp_q[k].mem_read && exp_q[k].rd != 0 &&
               in_valid && depends_on(inst, exp_q[k].rd);
         rdy = !rst && adv && !stl && !flush;
         chk($sformatf("in_ready%0d", k), 128'(in_ready[k]), 128'(rdy));
         if (rst || flush)         nxt[k] = '0;
         else if (!adv)            nxt[k] = exp_q[k];
         else if (in_valid && rdy) nxt[k] = decode_ref(inst, pc_plus4, k == 0);
         else                      nxt[k] = '0;
         if (k == 0) acc0 = in_valid && rdy;
      end
      @(posedge clk);
      exp_q = nxt;
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("outputs%0d", k), 128'(obs[k]), 128'(exp_q[k]));
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc);
      in_valid = v; inst = i; pc_plus4 = pc;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [5:0] ops [12];
      logic [5:0] fns [9];
      logic [5:0] op;
      ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h03};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08, 6'h3F};
      op = ($urandom_range(0, 15) == 0) ? 6'h3F : ops[$urandom_range(0, 11)];
      if (op == 6'h00)
         return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom), fns[$urandom_range(0, 8)]};
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
   endfunction

   initial begin
      exp_q[0] = '0; exp_q[1] = '0;
      rst = 1; flush = 0; out_ready = 1;
      drive(0, 32'h0, 32'h0);
      cyc(); cyc();
      chk("rst_valid", 128'(out_valid[0]), 0);
      chk("rst_ready", 128'(in_ready[0]), 0);
      rst = 0;

      drive(1, 32'h00221820, 32'h4); cyc();
      chk("add_valid", 128'(out_valid[0]), 1);
      chk("add_we", 128'(gp_we[0]), 1);
      chk("add_aluop", 128'(alu_op[0]), 0);
      chk("add_rd", 128'(rd_dest[0]), 3);
      chk("add_illegal", 128'(illegal[0]), 0);

      drive(1, 32'h34058001, 32'h8); cyc();
      chk("ori_imm", 128'(imm[0]), 128'h00008001);
      chk("ori_u", 128'(u[0]), 1);
      drive(1, 32'h20058001, 32'hC); cyc();
      chk("addi_imm", 128'(imm[0]), 128'hFFFF8001);
      chk("addi_u", 128'(u[0]), 0);

      drive(1, 32'h8C240000, 32'h10); cyc();
      chk("lw_valid", 128'(out_valid[0]), 1);
      drive(1, 32'h00823020, 32'h14);
      #1;
      chk("stall_ready", 128'(in_ready[0]), 0);
      chk("nohaz_ready", 128'(in_ready[1]), 1);
      cyc();
      chk("bubble_valid", 128'(out_valid[0]), 0);
      chk("nohaz_valid", 128'(out_valid[1]), 1);
      cyc();
      chk("after_bubble_valid", 128'(out_valid[0]), 1);
      chk("after_bubble_rd", 128'(rd_dest[0]), 6);
      drive(0, 32'h0, 32'h0); cyc();

      drive(1, 32'hAC220004, 32'h18); cyc();
      chk("sw_memwrite", 128'(mem_write[0]), 1);
      out_ready = 0;
      drive(1, 32'h00221820, 32'h1C);
      repeat (3) begin
         #1;
         chk("hold_ready", 128'(in_ready[0]), 0);
         cyc();
         chk("hold_memwrite", 128'(mem_write[0]), 1);
         chk("hold_imm", 128'(imm[0]), 4);
      end
      out_ready = 1; cyc();
      chk("release_memwrite", 128'(mem_write[0]), 0);
      chk("release_rd", 128'(rd_dest[0]), 3);

      drive(1, 32'h0C000010, 32'h104); cyc();
      chk("jal_pcmux", 128'(pc_mux[0]), 2);
      chk("jal_gpmux", 128'(gp_mux[0]), 3);
      chk("jal_rd", 128'(rd_dest[0]), 31);
      chk("jal_pc4", 128'(pc4_q[0]), 128'h104);
      drive(1, 32'h10220003, 32'h108); cyc();
      chk("beq_pcmux", 128'(pc_mux[0]), 1);
      chk("beq_bce", 128'(bce_op[0]), 1);
      chk("beq_nobr_illegal", 128'(illegal[1]), 1);
      chk("beq_nobr_pcmux", 128'(pc_mux[1]), 0);
      chk("beq_nobr_valid", 128'(out_valid[1]), 1);

      drive(1, 32'h00221820, 32'h10C); flush = 1;
      #1;
      chk("flush_ready", 128'(in_ready[0]), 0);
      cyc();
      chk("flush_valid", 128'(out_valid[0]), 0);
      flush = 0;

      drive(1, 32'h8C240000, 32'h200); cyc();
      drive(1, 32'h00823020, 32'h204);
      #1;
      chk("rst_stall_ready", 128'(in_ready[0]), 0);
      rst = 1; cyc();
      chk("rst_stall_valid", 128'(out_valid[0]), 0);
      chk("rst_stall_memread", 128'(mem_read[0]), 0);
      chk("rst_stall_rd", 128'(rd_dest[0]), 0);
      rst = 0;

      for (int n = 0; n < 800; n++) begin
         if (!(in_valid && !acc0)) begin
            inst = rand_inst();
            pc_plus4 = $urandom;
         end
         in_valid  = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
